// File: rtl/tmds_encoder_pipe_if.sv
// Bus between the HDMI packet/timing assembler and the pipelined TMDS encoder.
// TMDS_DISPARITY_MON_EN adds the per-lane disparity monitor outputs.
interface tmds_encoder_pipe_if #(
  parameter int unsigned NUM_CHANNELS = 3
`ifdef TMDS_DISPARITY_MON_EN
  ,
  parameter int unsigned DISP_W       = 6
`endif
);
  logic                      ce;
  logic [2:0]                mode;
  logic [8*NUM_CHANNELS-1:0] video_data;
  logic [4*NUM_CHANNELS-1:0] data_island_data;
  logic [2*NUM_CHANNELS-1:0] control_data;
  logic [10*NUM_CHANNELS-1:0] tmds;
  logic                      tmds_valid;

`ifdef TMDS_DISPARITY_MON_EN
  logic [NUM_CHANNELS-1:0]        disp_err;
  logic [DISP_W*NUM_CHANNELS-1:0] disp_acc;

  modport master (
    output ce, mode, video_data, data_island_data, control_data,
    input  tmds, tmds_valid, disp_err, disp_acc
  );
  modport slave (
    input  ce, mode, video_data, data_island_data, control_data,
    output tmds, tmds_valid, disp_err, disp_acc
  );
`else
  modport master (
    output ce, mode, video_data, data_island_data, control_data,
    input  tmds, tmds_valid
  );
  modport slave (
    input  ce, mode, video_data, data_island_data, control_data,
    output tmds, tmds_valid
  );
`endif
endinterface

// File: rtl/tmds_encoder_pipe.sv
// Multi-lane TMDS/TERC4 encoder: stage 1 builds q_m, stage 2 applies DC balance per lane.
// Define TMDS_DISPARITY_MON_EN to add the sticky disparity monitor (disp_err, disp_acc).
module tmds_encoder_pipe #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned DISP_W       = 6
) (
  input logic                clk_pixel,
  input logic                reset,
  tmds_encoder_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    ModeCtrl     = 3'd0,
    ModeVideo    = 3'd1,
    ModeVidGuard = 3'd2,
    ModeIsland   = 3'd3,
    ModeIslGuard = 3'd4
  } mode_e;

  localparam logic [9:0] CtrlIdle  = 10'h354;
  localparam logic [9:0] GuardEven = 10'h2CC;
  localparam logic [9:0] GuardOdd  = 10'h133;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_enc(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    s = CtrlIdle;
    unique case (c)
      2'b00: s = 10'h354;
      2'b01: s = 10'h0AB;
      2'b10: s = 10'h154;
      2'b11: s = 10'h2AB;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] s;
    s = 10'h29C;
    unique case (d)
      4'h0: s = 10'h29C;
      4'h1: s = 10'h263;
      4'h2: s = 10'h2E4;
      4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;
      4'h5: s = 10'h11E;
      4'h6: s = 10'h18E;
      4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;
      4'h9: s = 10'h139;
      4'hA: s = 10'h19C;
      4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;
      4'hD: s = 10'h271;
      4'hE: s = 10'h163;
      4'hF: s = 10'h2C3;
    endcase
    return s;
  endfunction

  // Stage 1 state
  logic [2:0]                mode_q;
  logic [8:0]                qm_d [NUM_CHANNELS];
  logic [8:0]                qm_q [NUM_CHANNELS];
  logic [3:0]                n1_d [NUM_CHANNELS];
  logic [3:0]                n1_q [NUM_CHANNELS];
  logic [4*NUM_CHANNELS-1:0] isl_q;
  logic [2*NUM_CHANNELS-1:0] ctl_q;
  logic                      valid_s1_q;

  // Stage 2 state
  logic [9:0]               tmds_d [NUM_CHANNELS];
  logic [9:0]               tmds_q [NUM_CHANNELS];
  logic signed [DISP_W-1:0] acc_d  [NUM_CHANNELS];
  logic signed [DISP_W-1:0] acc_q  [NUM_CHANNELS];
  logic                     tmds_valid_q;

  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      qm_d[k] = qm_enc(bus.video_data[8*k +: 8]);
      n1_d[k] = ones8(qm_d[k][7:0]);
    end
  end

  always_comb begin : s2_comb
    int diff;
    int add;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      tmds_d[k] = tmds_q[k];
      acc_d[k]  = '0;
      diff      = 2 * int'(n1_q[k]) - 8;  // N1 - N0
      add       = 0;
      case (mode_q)
        ModeCtrl:     tmds_d[k] = ctrl_sym(ctl_q[2*k +: 2]);
        ModeVideo: begin
          if ((acc_q[k] == '0) || (diff == 0)) begin
            tmds_d[k] = {~qm_q[k][8], qm_q[k][8],
                         qm_q[k][8] ? qm_q[k][7:0] : ~qm_q[k][7:0]};
            add       = qm_q[k][8] ? diff : -diff;
          end else if ((!acc_q[k][DISP_W-1] && (diff > 0)) ||
                       (acc_q[k][DISP_W-1] && (diff < 0))) begin
            tmds_d[k] = {1'b1, qm_q[k][8], ~qm_q[k][7:0]};
            add       = -diff + (qm_q[k][8] ? 2 : 0);
          end else begin
            tmds_d[k] = {1'b0, qm_q[k][8], qm_q[k][7:0]};
            add       = diff - (qm_q[k][8] ? 0 : 2);
          end
          acc_d[k] = DISP_W'(int'(acc_q[k]) + add);
        end
        ModeVidGuard: tmds_d[k] = ((k % 2) == 0) ? GuardEven : GuardOdd;
        ModeIsland:   tmds_d[k] = terc4(isl_q[4*k +: 4]);
        ModeIslGuard: tmds_d[k] = (k == 0) ? terc4({2'b11, ctl_q[1:0]}) : GuardOdd;
        default:      ;  // reserved modes hold the last symbol
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_q       <= '0;
      isl_q        <= '0;
      ctl_q        <= '0;
      valid_s1_q   <= 1'b0;
      tmds_valid_q <= 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        qm_q[k]   <= '0;
        n1_q[k]   <= '0;
        tmds_q[k] <= CtrlIdle;
        acc_q[k]  <= '0;
      end
    end else if (bus.ce) begin
      mode_q       <= bus.mode;
      isl_q        <= bus.data_island_data;
      ctl_q        <= bus.control_data;
      valid_s1_q   <= 1'b1;
      tmds_valid_q <= valid_s1_q;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        qm_q[k]   <= qm_d[k];
        n1_q[k]   <= n1_d[k];
        tmds_q[k] <= tmds_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

  always_comb begin
    bus.tmds = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) bus.tmds[10*k +: 10] = tmds_q[k];
  end

  assign bus.tmds_valid = tmds_valid_q;

`ifdef TMDS_DISPARITY_MON_EN
  logic [NUM_CHANNELS-1:0] disp_err_d;
  logic [NUM_CHANNELS-1:0] disp_err_q;

  always_comb begin
    disp_err_d = disp_err_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if ((int'(acc_d[k]) > 10) || (int'(acc_d[k]) < -10)) disp_err_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      disp_err_q <= '0;
    end else if (bus.ce) begin
      disp_err_q <= disp_err_d;
    end
  end

  always_comb begin
    bus.disp_acc = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) bus.disp_acc[DISP_W*k +: DISP_W] = acc_q[k];
  end

  assign bus.disp_err = disp_err_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Bench for tmds_encoder_pipe: directed vector table, random video with stalls, mixed modes.
// Compile with TMDS_DISPARITY_MON_EN to also check the disparity monitor outputs.
module tb_tmds_encoder_pipe;
  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 6;
  localparam int unsigned TW  = 10 * NCH;
  localparam int unsigned AW  = DW * NCH;

  localparam logic [9:0] TERC4 [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };
  localparam logic [9:0] CTRL [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  typedef struct {
    logic [TW-1:0] tmds;
    logic [AW-1:0] acc;
    bit            acc_chk;
  } sb_t;

  typedef struct {
    logic [2:0]     mode;
    logic [8*NCH-1:0] vid;
    logic [4*NCH-1:0] isl;
    logic [2*NCH-1:0] ctl;
    logic [TW-1:0]  exp;
    logic [AW-1:0]  acc;
  } vec_t;

  logic clk_pixel = 1'b0;
  logic reset     = 1'b1;
  always #5 clk_pixel = ~clk_pixel;

`ifdef TMDS_DISPARITY_MON_EN
  tmds_encoder_pipe_if #(.NUM_CHANNELS(NCH), .DISP_W(DW)) bus ();
`else
  tmds_encoder_pipe_if #(.NUM_CHANNELS(NCH)) bus ();
`endif

  tmds_encoder_pipe #(.NUM_CHANNELS(NCH), .DISP_W(DW)) dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  int         total = 0;
  int         bad   = 0;
  sb_t        sb [$];
  sb_t        last;
  int         m_acc  [NCH];
  logic [9:0] m_last [NCH];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] pack3(input int a0, input int a1, input int a2);
    return {DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic vec_t mk(input logic [2:0] m, input logic [23:0] v, input logic [11:0] i,
                              input logic [5:0] c, input logic [29:0] x, input logic [17:0] a);
    vec_t r;
    r.mode = m; r.vid = v; r.isl = i; r.ctl = c; r.exp = x; r.acc = a;
    return r;
  endfunction

  // Reference encoder, straight from the symbol rules, one symbol per call.
  task automatic model_step(input logic [2:0] m, input logic [23:0] v, input logic [11:0] isl,
                            input logic [5:0] c, output sb_t e);
    for (int k = 0; k < NCH; k++) begin
      logic [7:0] d;
      logic [7:0] q;
      logic       q8;
      int         ones, n1, n0;
      logic [9:0] o;
      d    = v[8*k +: 8];
      ones = $countones(d);
      q8   = !((ones > 4) || (ones == 4 && d[0] == 1'b0));
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : !(q[i-1] ^ d[i]);
      n1 = $countones(q);
      n0 = 8 - n1;
      o  = m_last[k];
      case (m)
        3'd0: o = CTRL[c[2*k +: 2]];
        3'd1: begin
          if (m_acc[k] == 0 || n1 == n0) begin
            o = {!q8, q8, q8 ? q : ~q};
            m_acc[k] += q8 ? (n1 - n0) : (n0 - n1);
          end else if ((m_acc[k] > 0 && n1 > n0) || (m_acc[k] < 0 && n1 < n0)) begin
            o = {1'b1, q8, ~q};
            m_acc[k] += n0 - n1 + (q8 ? 2 : 0);
          end else begin
            o = {1'b0, q8, q};
            m_acc[k] += n1 - n0 - (q8 ? 0 : 2);
          end
        end
        3'd2: o = (k % 2 == 0) ? 10'h2CC : 10'h133;
        3'd3: o = TERC4[isl[4*k +: 4]];
        3'd4: o = (k == 0) ? TERC4[{2'b11, c[1:0]}] : 10'h133;
        default: ;
      endcase
      if (m != 3'd1) m_acc[k] = 0;
      m_last[k] = o;
      e.tmds[10*k +: 10] = o;
      e.acc[DW*k +: DW]  = DW'(m_acc[k]);
    end
    e.acc_chk = 1'b1;
  endtask

  task automatic check_front();
    sb_t e;
    e = sb.pop_front();
    cmp("tmds", bus.tmds, e.tmds);
    cmp("valid", bus.tmds_valid, 1'b1);
`ifdef TMDS_DISPARITY_MON_EN
    if (e.acc_chk) cmp("disp_acc", bus.disp_acc, e.acc);
    cmp("disp_err", bus.disp_err, 64'd0);
`endif
    last = e;
  endtask

  task automatic drive(input logic [2:0] m, input logic [23:0] v, input logic [11:0] isl,
                       input logic [5:0] c, input sb_t e);
    bus.ce               = 1'b1;
    bus.mode             = m;
    bus.video_data       = v;
    bus.data_island_data = isl;
    bus.control_data     = c;
    sb.push_back(e);
    @(posedge clk_pixel);
    #1;
    if (sb.size() > 1) begin
      check_front();
    end else begin
      cmp("first_tmds", bus.tmds, {NCH{10'h354}});
      cmp("first_valid", bus.tmds_valid, 1'b0);
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ce               = 1'b0;
      bus.mode             = 3'($urandom_range(0, 7));
      bus.video_data       = 24'($urandom);
      bus.data_island_data = 12'($urandom);
      bus.control_data     = 6'($urandom);
      @(posedge clk_pixel);
      #1;
      cmp("stall_tmds", bus.tmds, last.tmds);
      cmp("stall_valid", bus.tmds_valid, 1'b1);
`ifdef TMDS_DISPARITY_MON_EN
      if (last.acc_chk) cmp("stall_acc", bus.disp_acc, last.acc);
`endif
    end
  endtask

  // Reset with ce high and live video on the inputs: reset must win.
  task automatic do_reset();
    reset                = 1'b1;
    bus.ce               = 1'b1;
    bus.mode             = 3'd1;
    bus.video_data       = 24'($urandom);
    bus.data_island_data = 12'($urandom);
    bus.control_data     = 6'($urandom);
    @(posedge clk_pixel);
    #1;
    cmp("rst_tmds", bus.tmds, {NCH{10'h354}});
    cmp("rst_valid", bus.tmds_valid, 1'b0);
`ifdef TMDS_DISPARITY_MON_EN
    cmp("rst_acc", bus.disp_acc, 64'd0);
    cmp("rst_err", bus.disp_err, 64'd0);
`endif
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < NCH; k++) begin
      m_acc[k]  = 0;
      m_last[k] = 10'h354;
    end
    last.tmds    = {NCH{10'h354}};
    last.acc     = '0;
    last.acc_chk = 1'b1;
  endtask

  initial begin
    vec_t tab [17];
    sb_t  e;

    tab[0]  = mk(3'd0, 24'h0, 12'h0, 6'h00, {3{10'h354}}, pack3(0, 0, 0));
    tab[1]  = mk(3'd0, 24'h0, 12'h0, 6'h00, {3{10'h354}}, pack3(0, 0, 0));
    tab[2]  = mk(3'd0, 24'h0, 12'h0, 6'h00, {3{10'h354}}, pack3(0, 0, 0));
    tab[3]  = mk(3'd1, 24'h0, 12'h0, 6'h00, {3{10'h100}}, pack3(-8, -8, -8));
    tab[4]  = mk(3'd1, 24'h0, 12'h0, 6'h00, {3{10'h3FF}}, pack3(2, 2, 2));
    tab[5]  = mk(3'd1, 24'h0, 12'h0, 6'h00, {3{10'h100}}, pack3(-6, -6, -6));
    tab[6]  = mk(3'd0, 24'h0, 12'h0, 6'h00, {3{10'h354}}, pack3(0, 0, 0));
    tab[7]  = mk(3'd1, 24'h00FF00, 12'h0, 6'h00, {10'h100, 10'h200, 10'h100},
                 pack3(-8, -8, -8));
    tab[8]  = mk(3'd4, 24'h0, 12'h0, 6'b111110, {10'h133, 10'h133, 10'h163}, pack3(0, 0, 0));
    tab[9]  = mk(3'd2, 24'hABCDEF, 12'h123, 6'h15, {10'h2CC, 10'h133, 10'h2CC},
                 pack3(0, 0, 0));
    tab[10] = mk(3'd3, 24'h0, 12'hF50, 6'h00, {10'h2C3, 10'h11E, 10'h29C}, pack3(0, 0, 0));
    tab[11] = mk(3'd0, 24'h0, 12'h0, 6'b111001, {10'h2AB, 10'h154, 10'h0AB}, pack3(0, 0, 0));
    tab[12] = mk(3'd6, 24'h123456, 12'hFFF, 6'h3F, {10'h2AB, 10'h154, 10'h0AB},
                 pack3(0, 0, 0));
    tab[13] = mk(3'd1, 24'h0, 12'h0, 6'h00, {3{10'h100}}, pack3(-8, -8, -8));
    tab[14] = mk(3'd1, 24'h0, 12'h0, 6'h00, {3{10'h3FF}}, pack3(2, 2, 2));
    tab[15] = mk(3'd3, 24'h0, 12'h9C1, 6'h00, {10'h139, 10'h28E, 10'h263}, pack3(0, 0, 0));
    tab[16] = mk(3'd0, 24'h0, 12'h0, 6'h00, {3{10'h354}}, pack3(0, 0, 0));

    bus.ce               = 1'b0;
    bus.mode             = 3'd0;
    bus.video_data       = '0;
    bus.data_island_data = '0;
    bus.control_data     = '0;

    do_reset();
    for (int i = 0; i < 17; i++) begin
      e.tmds    = tab[i].exp;
      e.acc     = tab[i].acc;
      e.acc_chk = 1'b1;
      drive(tab[i].mode, tab[i].vid, tab[i].isl, tab[i].ctl, e);
    end

    // Long random video burst with a stall; ends in a mid-burst reset.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [23:0] v;
      logic [11:0] isl;
      logic [5:0]  c;
      if (i == 20) stall(4);
      v   = 24'($urandom);
      isl = 12'($urandom);
      c   = 6'($urandom);
      model_step(3'd1, v, isl, c, e);
      drive(3'd1, v, isl, c, e);
`ifdef TMDS_DISPARITY_MON_EN
      for (int k = 0; k < NCH; k++) begin
        int a;
        a = int'($signed(bus.disp_acc[DW*k +: DW]));
        total++;
        if (a > 10 || a < -10) begin
          bad++;
          $display("FAIL acc_bound lane %0d: got %0d, want magnitude <= 10", k, a);
        end
      end
`endif
    end
    do_reset();

    // Mixed modes, including reserved ones, with a short stall.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  m;
      logic [23:0] v;
      logic [11:0] isl;
      logic [5:0]  c;
      if (i == 30) stall(3);
      m   = 3'($urandom_range(0, 7));
      v   = 24'($urandom);
      isl = 12'($urandom);
      c   = 6'($urandom);
      model_step(m, v, isl, c, e);
      drive(m, v, isl, c, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
